// File: rtl/cm811_init_supervisor.sv
// Supervisor for the CM811 init sequencer: power-up delay, per-attempt watchdog,
// abort reset on hang, retry with backoff, and board-level ready/fatal reporting.
module cm811_init_supervisor #(
    parameter int PWRUP_DLY    = 1000,
    parameter int TIMEOUT_CYC  = 1000000,
    parameter int ABORT_CYC    = 16,
    parameter int BACKOFF_CYC  = 256,
    parameter int MAX_ATTEMPTS = 4,
    parameter int TIMER_W      = 24
) (
    input  logic       sys_clk,
    input  logic       glbl_rst_n,
    input  logic       reinit_req,
    input  logic       init_ok,
    input  logic       init_fail,
    output logic       init_start,
    output logic       init_rst_n,
    output logic       sys_ready,
    output logic       sys_fatal,
    output logic [3:0] attempt_cnt,
    output logic [1:0] last_err
);

    // state      | meaning
    // ST_PWRUP   | waiting out the power-up delay
    // ST_START   | init_start high for this one cycle
    // ST_WAIT    | response window open, watchdog running
    // ST_ABORT   | init_rst_n held low after a timeout
    // ST_BACKOFF | pause before the next attempt
    // ST_READY   | board initialised, waiting for reinit_req
    // ST_FATAL   | attempt limit exhausted, waiting for reinit_req
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_START,
        ST_WAIT,
        ST_ABORT,
        ST_BACKOFF,
        ST_READY,
        ST_FATAL
    } state_t;

    // Down-counter loads; the power-up load includes the cycle spent in START.
    localparam logic [TIMER_W-1:0] L_PWRUP   = TIMER_W'(PWRUP_DLY + 1);
    localparam logic [TIMER_W-1:0] L_TIMEOUT = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] L_ABORT   = TIMER_W'(ABORT_CYC - 1);
    localparam logic [TIMER_W-1:0] L_BACKOFF = TIMER_W'(BACKOFF_CYC - 1);
    localparam logic [3:0]         L_MAX     = 4'(MAX_ATTEMPTS);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FAIL    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_init_start;
    logic                 r_init_rst_n;
    logic                 r_sys_ready;
    logic                 r_sys_fatal;
    logic [3:0]           r_attempt;
    logic [1:0]           r_last_err;

    logic                 w_timer_tc;
    logic                 w_limit;

    assign w_timer_tc = (r_timer == '0);
    assign w_limit    = (r_attempt == L_MAX);

    always_ff @(posedge sys_clk) begin
        if (!glbl_rst_n) begin
            r_state      <= ST_PWRUP;
            r_timer      <= L_PWRUP;
            r_init_start <= 1'b0;
            r_init_rst_n <= 1'b1;
            r_sys_ready  <= 1'b0;
            r_sys_fatal  <= 1'b0;
            r_attempt    <= 4'd0;
            r_last_err   <= ERR_NONE;
        end else begin
            r_init_start <= 1'b0;
            case (r_state)
                ST_PWRUP: begin
                    if (w_timer_tc) begin
                        r_state      <= ST_START;
                        r_init_start <= 1'b1;
                        if (!w_limit) r_attempt <= r_attempt + 4'd1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_START: begin
                    r_timer <= L_TIMEOUT;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (init_fail) begin
                        r_last_err <= ERR_FAIL;
                        if (w_limit) begin
                            r_sys_fatal <= 1'b1;
                            r_state     <= ST_FATAL;
                        end else begin
                            r_timer <= L_BACKOFF;
                            r_state <= ST_BACKOFF;
                        end
                    end else if (init_ok) begin
                        r_last_err  <= ERR_NONE;
                        r_sys_ready <= 1'b1;
                        r_state     <= ST_READY;
                    end else if (w_timer_tc) begin
                        r_last_err   <= ERR_TIMEOUT;
                        r_init_rst_n <= 1'b0;
                        r_timer      <= L_ABORT;
                        r_state      <= ST_ABORT;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_ABORT: begin
                    if (w_timer_tc) begin
                        r_init_rst_n <= 1'b1;
                        if (w_limit) begin
                            r_sys_fatal <= 1'b1;
                            r_state     <= ST_FATAL;
                        end else begin
                            r_timer <= L_BACKOFF;
                            r_state <= ST_BACKOFF;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (w_timer_tc) begin
                        r_state      <= ST_START;
                        r_init_start <= 1'b1;
                        if (!w_limit) r_attempt <= r_attempt + 4'd1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_READY: begin
                    if (reinit_req) begin
                        r_sys_ready  <= 1'b0;
                        r_last_err   <= ERR_NONE;
                        r_attempt    <= 4'd1;
                        r_init_start <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                ST_FATAL: begin
                    if (reinit_req) begin
                        r_sys_fatal  <= 1'b0;
                        r_last_err   <= ERR_NONE;
                        r_attempt    <= 4'd1;
                        r_init_start <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                default: begin
                    r_state <= ST_PWRUP;
                    r_timer <= L_PWRUP;
                end
            endcase
        end
    end

    assign init_start  = r_init_start;
    assign init_rst_n  = r_init_rst_n;
    assign sys_ready   = r_sys_ready;
    assign sys_fatal   = r_sys_fatal;
    assign attempt_cnt = r_attempt;
    assign last_err    = r_last_err;

endmodule

// File: tb/tb_cm811_init_supervisor.sv
// Scoreboard bench: stimulus predicts the cycle of each observable event from the
// supervisor's timing rules; a negedge monitor pops and compares as events occur.
module tb_cm811_init_supervisor;

    localparam int PD = 8;
    localparam int TO = 64;
    localparam int AB = 4;
    localparam int BO = 16;
    localparam int MA = 3;

    localparam int EV_START = 0;
    localparam int EV_ALO   = 1;
    localparam int EV_AHI   = 2;
    localparam int EV_READY = 3;
    localparam int EV_FATAL = 4;

    localparam int P_REINIT = 0;
    localparam int P_OK     = 1;
    localparam int P_FAIL   = 2;
    localparam int P_BOTH   = 3;

    logic       clk = 1'b0;
    logic       glbl_rst_n = 1'b0;
    logic       reinit_req = 1'b0;
    logic       init_ok = 1'b0;
    logic       init_fail = 1'b0;
    logic       init_start;
    logic       init_rst_n;
    logic       sys_ready;
    logic       sys_fatal;
    logic [3:0] attempt_cnt;
    logic [1:0] last_err;

    cm811_init_supervisor #(
        .PWRUP_DLY(PD), .TIMEOUT_CYC(TO), .ABORT_CYC(AB),
        .BACKOFF_CYC(BO), .MAX_ATTEMPTS(MA), .TIMER_W(12)
    ) dut (
        .sys_clk(clk), .glbl_rst_n(glbl_rst_n), .reinit_req(reinit_req),
        .init_ok(init_ok), .init_fail(init_fail), .init_start(init_start),
        .init_rst_n(init_rst_n), .sys_ready(sys_ready), .sys_fatal(sys_fatal),
        .attempt_cnt(attempt_cnt), .last_err(last_err)
    );

    always #5 clk = ~clk;

    // cyc == n during the cycle following edge n; edge 0 is the first one out of reset
    int cyc = -1;
    always @(posedge clk) begin
        if (!glbl_rst_n) cyc <= -1;
        else             cyc <= cyc + 1;
    end

    typedef struct {
        int kind;
        int tcy;
        int att;
        int err;
    } ev_t;

    ev_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    function automatic string ev_name(int k);
        case (k)
            EV_START: return "START";
            EV_ALO:   return "ABORT_LO";
            EV_AHI:   return "ABORT_HI";
            EV_READY: return "READY";
            default:  return "FATAL";
        endcase
    endfunction

    task automatic push(input int k, input int c, input int a, input int e);
        ev_t x;
        x.kind = k; x.tcy = c; x.att = a; x.err = e;
        sb.push_back(x);
    endtask

    task automatic check_val(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        bit  bad;
        bit  chk_rf;
        int  exp_r;
        int  exp_f;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_%s: seen at cycle %0d, expected no event", ev_name(kind), cyc);
            return;
        end
        e = sb.pop_front();
        chk_rf = (e.kind != EV_AHI);
        exp_r  = (e.kind == EV_READY) ? 1 : 0;
        exp_f  = (e.kind == EV_FATAL) ? 1 : 0;
        bad = (e.kind != kind) || (e.tcy != cyc) || (e.att != int'(attempt_cnt)) ||
              (e.err != int'(last_err)) ||
              (chk_rf && ((int'(sys_ready) != exp_r) || (int'(sys_fatal) != exp_f))) ||
              (sys_ready && sys_fatal);
        if (bad) begin
            n_err++;
            $display("FAIL ev_%s: got %s cyc=%0d att=%0d err=%0d rdy=%0d fat=%0d, expected %s cyc=%0d att=%0d err=%0d",
                     ev_name(e.kind), ev_name(kind), cyc, attempt_cnt, last_err, sys_ready, sys_fatal,
                     ev_name(e.kind), e.tcy, e.att, e.err);
        end
    endtask

    logic p_rst_n = 1'b1;
    logic p_ready = 1'b0;
    logic p_fatal = 1'b0;

    always @(negedge clk) begin
        if (glbl_rst_n && cyc >= 0) begin
            if (init_start)             check_event(EV_START);
            if (p_rst_n && !init_rst_n) check_event(EV_ALO);
            if (!p_rst_n && init_rst_n) check_event(EV_AHI);
            if (!p_ready && sys_ready)  check_event(EV_READY);
            if (!p_fatal && sys_fatal)  check_event(EV_FATAL);
        end
        p_rst_n <= init_rst_n;
        p_ready <= sys_ready;
        p_fatal <= sys_fatal;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input int c, input int which);
        n_vec++;
        if (cyc > c) begin
            n_err++;
            $display("FAIL drive_slot: now at cycle %0d, required cycle %0d", cyc, c);
        end
        wait_until(c);
        case (which)
            P_REINIT: reinit_req = 1'b1;
            P_OK:     init_ok = 1'b1;
            P_FAIL:   init_fail = 1'b1;
            default:  begin init_ok = 1'b1; init_fail = 1'b1; end
        endcase
        @(negedge clk);
        reinit_req = 1'b0;
        init_ok    = 1'b0;
        init_fail  = 1'b0;
    endtask

    // plan codes: 0 ok (random delay), 1 fail, 2 ok+fail together, 3 no response,
    // 4 ok on last window cycle, 5 ok one cycle after the window, 6 ok at delay 10
    task automatic campaign(input int t0, input int plan[MA], input bit wreinit,
                            output bit got_ready, output int t_end);
        int t;
        int d;
        int code;
        t = t0;
        got_ready = 1'b0;
        t_end = t0;
        for (int k = 1; k <= MA; k++) begin
            code = plan[k-1];
            case (code)
                0:       d = int'($urandom_range(1, TO));
                4:       d = TO;
                5:       d = TO + 1;
                6:       d = 10;
                default: d = int'($urandom_range(1, TO));
            endcase
            if (wreinit && (code == 3 || d >= 3)) pulse(t + 1, P_REINIT);
            if (code == 0 || code == 4 || code == 6) begin
                push(EV_READY, t + d + 1, k, 0);
                pulse(t + d, P_OK);
                got_ready = 1'b1;
                t_end = t + d + 1;
                return;
            end else if (code == 1 || code == 2) begin
                if (k == MA) push(EV_FATAL, t + d + 1, k, 1);
                else         push(EV_START, t + d + BO + 1, k + 1, 1);
                pulse(t + d, (code == 1) ? P_FAIL : P_BOTH);
                if (k == MA) begin
                    t_end = t + d + 1;
                    return;
                end
                t = t + d + BO + 1;
            end else begin
                push(EV_ALO, t + TO + 1, k, 2);
                push(EV_AHI, t + TO + AB + 1, k, 2);
                if (k == MA) push(EV_FATAL, t + TO + AB + 1, k, 2);
                else         push(EV_START, t + TO + AB + BO + 1, k + 1, 2);
                if (code == 5) pulse(t + TO + 1, P_OK);
                if (k == MA) begin
                    t_end = t + TO + AB + 1;
                    wait_until(t_end);
                    return;
                end
                t = t + TO + AB + BO + 1;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_init_start"}, int'(init_start), 0);
        check_val({tag, "_init_rst_n"}, int'(init_rst_n), 1);
        check_val({tag, "_sys_ready"},  int'(sys_ready), 0);
        check_val({tag, "_sys_fatal"},  int'(sys_fatal), 0);
        check_val({tag, "_attempt"},    int'(attempt_cnt), 0);
        check_val({tag, "_last_err"},   int'(last_err), 0);
    endtask

    task automatic reinit_after(input int t_end, input bit was_ready, output int t_new);
        int r;
        r = t_end + int'($urandom_range(2, 20)) + (was_ready ? 0 : 60);
        push(EV_START, r + 1, 1, 0);
        pulse(r, P_REINIT);
        check_val("ready_cleared", int'(sys_ready), 0);
        check_val("fatal_cleared", int'(sys_fatal), 0);
        t_new = r + 1;
    endtask

    initial begin
        int  plan[MA];
        bit  rdy;
        int  te;
        int  t;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        glbl_rst_n = 1'b1;

        push(EV_START, PD + 1, 1, 0);
        plan = '{6, 0, 0};
        campaign(PD + 1, plan, 1'b0, rdy, te);

        for (int s = 0; s < 12; s++) begin
            reinit_after(te, rdy, t);
            case (s)
                0:       plan = '{1, 1, 0};
                1:       plan = '{3, 3, 3};
                2:       plan = '{2, 4, 0};
                3:       plan = '{5, 0, 0};
                default: begin
                    for (int i = 0; i < MA; i++) plan[i] = int'($urandom_range(0, 5));
                end
            endcase
            campaign(t, plan, (s == 0) || ($urandom_range(0, 1) == 1), rdy, te);
        end

        reinit_after(te, rdy, t);
        push(EV_ALO, t + TO + 1, 1, 2);
        wait_until(t + TO + 2);
        check_val("abort_rst_n_low", int'(init_rst_n), 0);
        glbl_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("abort_rst");
        glbl_rst_n = 1'b1;
        push(EV_START, PD + 1, 1, 0);
        plan = '{0, 0, 0};
        campaign(PD + 1, plan, 1'b0, rdy, te);

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check_val("pending_events", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "time limit");
    end

endmodule
